// File: rtl/sensor_sample_ram.sv
// sensor_sample_ram: single-clock sample store with random access, circular push port and clear engine
//
// Parameters : DATA_WIDTH (bits per word), ADDR_WIDTH (DEPTH = 2**ADDR_WIDTH words)
// Macro      : PARITY_EN - when defined, each word carries an even-parity bit checked on read
// Ports      : clk, rst_n (async active-low)
//              addr_i, data_in_i            random-access address / write-push data
//              write_i, read_i, push_i      access strobes (push beats write, read independent)
//              clear_i                      pulse to start a sequential array clear
//              data_out_o, rd_valid_o       registered read data and its one-cycle strobe
//              busy_o                       clear engine running, accesses dropped
//              wr_ptr_o, level_o, wrapped_o push pointer, saturating fill level, sticky wrap flag
//              parity_err_o                 read parity mismatch, aligned with rd_valid_o
module sensor_sample_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  write_i,
    input  logic                  read_i,
    input  logic                  push_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  rd_valid_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] wr_ptr_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  wrapped_o,
    output logic                  parity_err_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH:0]   level_q;
    logic                  wrapped_q;
    logic                  busy_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [MW-1:0]         mem_q [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MW-1:0]         mem_wdata;
    logic [MW-1:0]         in_word;
    logic [MW-1:0]         rd_word;

`ifdef PARITY_EN
    assign in_word = {^data_in_i, data_in_i};
`else
    assign in_word = data_in_i;
`endif
    assign rd_word = mem_q[addr_i];

    // Single write port: the clear engine owns it while clearing, otherwise push wins over write.
    always_comb begin
        mem_we    = (state_q == CLEAR) || push_i || write_i;
        mem_addr  = (state_q == CLEAR) ? cnt_q : (push_i ? wr_ptr_q : addr_i);
        mem_wdata = (state_q == CLEAR) ? '0 : in_word;
    end

    // Array itself has no reset; the clear engine zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_addr] <= mem_wdata;
    end

`ifdef PARITY_EN
    logic parity_err_q;
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            wrapped_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
`ifdef PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else if (state_q == CLEAR) begin
            cnt_q      <= cnt_q + 1'b1;
            rd_valid_q <= 1'b0;
            if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            rd_valid_q <= read_i;
            if (read_i) begin
                data_out_q <= rd_word[DATA_WIDTH-1:0];
`ifdef PARITY_EN
                // Even parity over data plus stored bit is zero for an intact word.
                parity_err_q <= ^rd_word;
`endif
            end
            if (clear_i) begin
                state_q   <= CLEAR;
                busy_q    <= 1'b1;
                cnt_q     <= '0;
                wr_ptr_q  <= '0;
                level_q   <= '0;
                wrapped_q <= 1'b0;
            end else if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) wrapped_q <= 1'b1;
                if (level_q != (ADDR_WIDTH + 1)'(DEPTH)) level_q <= level_q + 1'b1;
            end
        end
    end

    assign data_out_o = data_out_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = busy_q;
    assign wr_ptr_o   = wr_ptr_q;
    assign level_o    = level_q;
    assign wrapped_o  = wrapped_q;
endmodule

// File: tb/tb_sensor_sample_ram.sv
// tb_sensor_sample_ram: self-checking bench for sensor_sample_ram
module tb_sensor_sample_ram;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] data_in = '0;
    logic       write = 1'b0, read = 1'b0, push = 1'b0, clear = 1'b0;
    logic [7:0] data_out;
    logic       rd_valid, busy, wrapped, parity_err;
    logic [3:0] wr_ptr;
    logic [4:0] level;

    sensor_sample_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr), .data_in_i(data_in),
        .write_i(write), .read_i(read), .push_i(push), .clear_i(clear),
        .data_out_o(data_out), .rd_valid_o(rd_valid), .busy_o(busy),
        .wr_ptr_o(wr_ptr), .level_o(level), .wrapped_o(wrapped), .parity_err_o(parity_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit [7:0] m [16];
    int       e_wp, e_level;
    bit       e_wrapped, e_valid, e_perr;
    bit [7:0] e_dout;

    typedef struct {
        bit       we;
        bit       re;
        bit [3:0] a;
        bit [7:0] d;
        bit [7:0] exp_d;
        bit       exp_v;
    } vec_t;
    vec_t vecs [36];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m[i]) m[i] = 8'h00;
        e_wp = 0; e_level = 0; e_wrapped = 0;
    endtask

    // One idle-state cycle: drive, predict from the model, clock, compare.
    task automatic cyc(input bit we, input bit re, input bit pu, input bit [3:0] a, input bit [7:0] d);
        write = we; read = re; push = pu; addr = a; data_in = d; clear = 1'b0;
        e_valid = re;
        if (re) e_dout = m[a];
        if (pu) begin
            m[e_wp] = d;
            e_wp = (e_wp + 1) % 16;
            if (e_wp == 0) e_wrapped = 1;
            if (e_level < 16) e_level++;
        end else if (we) m[a] = d;
        @(posedge clk); #1;
        chk("data_out", data_out, e_dout);
        chk("rd_valid", rd_valid, e_valid);
        chk("wr_ptr", wr_ptr, e_wp);
        chk("level", level, e_level);
        chk("wrapped", wrapped, e_wrapped);
        chk("parity_err", parity_err, e_valid & e_perr);
        chk("busy_idle", busy, 0);
    endtask

    // Clear engine running: every access dropped, busy high until the last word.
    task automatic busy_run(input string nm, input int cycles);
        for (int i = 1; i <= cycles; i++) begin
            write = 1'b1; read = 1'b1; push = 1'b1; addr = 4'(i); data_in = 8'hFF;
            @(posedge clk); #1;
            chk({nm, "_busy"}, busy, (i < cycles) ? 1 : 0);
            chk({nm, "_rdv"}, rd_valid, 0);
        end
        write = 1'b0; read = 1'b0; push = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        e_dout = 0; e_valid = 0; e_perr = 0;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_level", level, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_perr", parity_err, 0);
        rst_n = 1'b1;
        // 1: busy exactly 16 cycles, then array reads zero
        busy_run("init", 16);
        for (int a = 0; a < 16; a++) cyc(0, 1, 0, 4'(a), 0);

        // 2 and 3: table of writes/reads with constant expectations
        for (int i = 0; i < 16; i++) vecs[i] = '{1, 0, 4'(i), 8'(2 * i), 8'h00, 0};
        for (int i = 0; i < 16; i++) vecs[16 + i] = '{0, 1, 4'(i), 8'h00, 8'(2 * i), 1};
        vecs[32] = '{1, 0, 4'd5, 8'h0A, 8'h1E, 0};
        vecs[33] = '{1, 1, 4'd5, 8'h55, 8'h0A, 1};
        vecs[34] = '{0, 1, 4'd5, 8'h00, 8'h55, 1};
        vecs[35] = '{0, 0, 4'd5, 8'h00, 8'h55, 0};
        foreach (vecs[i]) begin
            cyc(vecs[i].we, vecs[i].re, 0, vecs[i].a, vecs[i].d);
            chk("tbl_dout", data_out, vecs[i].exp_d);
            chk("tbl_rdv", rd_valid, vecs[i].exp_v);
        end

        // 4: 18 pushes wrap the pointer
        for (int k = 0; k < 18; k++) cyc(0, 0, 1, 4'd0, 8'(8'h80 + k));
        chk("push_wr_ptr", wr_ptr, 2);
        chk("push_level", level, 16);
        chk("push_wrapped", wrapped, 1);
        cyc(0, 1, 0, 4'd0, 0); chk("push_m0", data_out, 8'h90);
        cyc(0, 1, 0, 4'd1, 0); chk("push_m1", data_out, 8'h91);
        cyc(0, 1, 0, 4'd2, 0); chk("push_m2", data_out, 8'h82);
        // write+push together: push wins
        cyc(1, 0, 1, 4'd9, 8'hC3);
        cyc(0, 1, 0, 4'd2, 0); chk("pushwin_m2", data_out, 8'hC3);

        // random traffic against the model
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                4'($urandom), 8'($urandom));

        // 5: clear pulse, dropped write, reset mid-clear
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        chk("clr_busy", busy, 1);
        chk("clr_level", level, 0);
        chk("clr_wr_ptr", wr_ptr, 0);
        chk("clr_wrapped", wrapped, 0);
        write = 1'b1; addr = 4'd3; data_in = 8'h33; read = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        chk("clr_drop_rdv", rd_valid, 0);
        chk("clr_drop_busy", busy, 1);
        repeat (6) begin
            @(posedge clk); #1;
            chk("clr_mid_busy", busy, 1);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", busy, 1);
        rst_n = 1'b1;
        e_dout = 0; e_valid = 0;
        busy_run("restart", 16);
        for (int a = 0; a < 16; a++) cyc(0, 1, 0, 4'(a), 0);
        chk("post_level", level, 0);

        // 6: parity
        cyc(1, 0, 0, 4'd4, 8'h0F);
`ifdef PARITY_EN
        dut.mem_q[4][0] = ~dut.mem_q[4][0];
        m[4] = 8'h0E;
        e_perr = 1;
`endif
        cyc(0, 1, 0, 4'd4, 0);
        chk("parity_read", parity_err, e_perr);
        e_perr = 0;
        cyc(0, 1, 0, 4'd5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
